// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data_memory_ls load/store data memory:
//   - funct3 access-size codes (RISC-V LB/LH/LW/LBU/LHU, SB/SH/SW)
//   - clear/run FSM state type
//   - response record carried through the fixed-latency response pipeline
// -----------------------------------------------------------------------------
package dmem_pkg;

  // funct3 access-size codes
  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  // CLEAR runs once after every reset; RUN serves requests
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } fsm_e;

  // One entry of the response pipeline
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Combinational byte-lane steering for the data memory.
// Store side: from the request size/lane/data produce the byte enables and the
// write word with the store data replicated onto every candidate lane, plus
// the misalign / illegal-size flags.
// Load side: from the size/lane captured at accept and the word read from the
// array produce the shifted, sign- or zero-extended load result.
// Ports:
//   i_we        request is a store
//   i_req_size  request funct3
//   i_req_lane  request byte lane (addr[1:0])
//   i_wdata     right-aligned store data
//   i_rd_size   funct3 of the load being returned
//   i_rd_lane   byte lane of the load being returned
//   i_rword     word read from the array
//   o_be        per-byte write enables
//   o_wword     write word (data replicated across lanes)
//   o_rdata     extended load result
//   o_misalign  request is misaligned for its size
//   o_illegal   request size code is not legal for its direction
// -----------------------------------------------------------------------------
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_req_size,
  input  logic [1:0]  i_req_lane,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_rd_size,
  input  logic [1:0]  i_rd_lane,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic [31:0] o_rdata,
  output logic        o_misalign,
  output logic        o_illegal
);

  logic [31:0] w_shift;

  // Request checks
  always_comb begin
    o_misalign = 1'b0;
    o_illegal  = 1'b0;
    case (i_req_size)
      SZ_B:         o_illegal  = 1'b0;
      SZ_H:         o_misalign = i_req_lane[0];
      SZ_W:         o_misalign = |i_req_lane;
      SZ_BU:        o_illegal  = i_we;
      SZ_HU: begin
        o_misalign = i_req_lane[0];
        o_illegal  = i_we;
      end
      default:      o_illegal  = 1'b1;
    endcase
  end

  // Store steering: replicating the data means only the enables depend on
  // the lane, so no write-side shifter is needed.
  always_comb begin
    o_be    = 4'b0000;
    o_wword = i_wdata;
    case (i_req_size)
      SZ_B: begin
        o_be    = 4'b0001 << i_req_lane;
        o_wword = {4{i_wdata[7:0]}};
      end
      SZ_H: begin
        o_be    = 4'b0011 << i_req_lane;
        o_wword = {2{i_wdata[15:0]}};
      end
      SZ_W:    o_be = 4'b1111;
      default: o_be = 4'b0000;
    endcase
  end

  // Load steering: bring the addressed lane down to bit 0, then extend
  assign w_shift = i_rword >> {i_rd_lane, 3'b000};

  always_comb begin
    o_rdata = i_rword;
    case (i_rd_size)
      SZ_B:    o_rdata = {{24{w_shift[7]}}, w_shift[7:0]};
      SZ_BU:   o_rdata = {24'h0, w_shift[7:0]};
      SZ_H:    o_rdata = {{16{w_shift[15]}}, w_shift[15:0]};
      SZ_HU:   o_rdata = {16'h0, w_shift[15:0]};
      default: o_rdata = i_rword;
    endcase
  end

endmodule

// File: rtl/data_memory_ls.sv
// -----------------------------------------------------------------------------
// data_memory_ls
// Word-organised data memory for the MEM stage with RISC-V byte/half/word
// loads and stores, byte-enable writes and sign/zero extension. After every
// reset the array is cleared one word per cycle before requests are accepted.
// Responses (loads and stores alike) appear exactly RD_LATENCY cycles after
// the accept edge, in order, with no backpressure.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   req_valid  request present
//   req_ready  request can be accepted this cycle (low during clear)
//   req_we     1 = store, 0 = load
//   req_size   funct3 access size
//   req_addr   byte address
//   req_wdata  right-aligned store data
//   rsp_valid  one-cycle response strobe
//   rsp_rdata  extended load data; 0 for stores and faults
//   rsp_err    access fault (meaningful with rsp_valid)
//   init_busy  clear sequence in progress
// -----------------------------------------------------------------------------
module data_memory_ls
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 256,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_busy
);

  localparam int IDX_W = $clog2(MEM_SIZE);

  // FSM and clear pointer
  fsm_e             r_state;
  fsm_e             w_state_next;
  logic [IDX_W-1:0] r_clr_ptr;

  // Storage; the read port is registered so it maps onto block RAM
  logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];
  logic [DATA_WIDTH-1:0] r_rd_word;

  // Request decode
  logic             w_accept;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_lane;
  logic             w_oor;
  logic             w_misalign;
  logic             w_illegal;
  logic             w_err;
  logic             w_store;
  logic [3:0]       w_be;
  logic [31:0]      w_wword;
  logic [31:0]      w_ld_data;

  // Attributes of the request accepted on the previous edge
  logic       r_acc_valid;
  logic       r_acc_err;
  logic       r_acc_we;
  logic [2:0] r_acc_size;
  logic [1:0] r_acc_lane;

  // Response pipeline
  rsp_t w_stage0;
  rsp_t r_pipe [RD_LATENCY];

  // ---------------------------------------------------------------------------
  // Clear / run FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CLEAR:   if (r_clr_ptr == IDX_W'(MEM_SIZE - 1)) w_state_next = RUN;
      RUN:     w_state_next = RUN;
      default: w_state_next = CLEAR;
    endcase
  end

  always_comb begin
    init_busy = 1'b0;
    req_ready = 1'b0;
    case (r_state)
      CLEAR:   init_busy = 1'b1;
      RUN:     req_ready = 1'b1;
      default: init_busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clr_ptr <= '0;
    end else if (r_state == CLEAR) begin
      r_clr_ptr <= r_clr_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Request decode and lane steering
  // ---------------------------------------------------------------------------
  assign w_accept = req_valid && req_ready;
  assign w_idx    = req_addr[2 +: IDX_W];
  assign w_lane   = req_addr[1:0];
  assign w_oor    = |req_addr[ADDR_WIDTH-1:IDX_W+2];
  assign w_err    = w_oor | w_misalign | w_illegal;
  assign w_store  = w_accept && req_we && !w_err;

  dmem_lane_align u_align (
    .i_we       (req_we),
    .i_req_size (req_size),
    .i_req_lane (w_lane),
    .i_wdata    (req_wdata),
    .i_rd_size  (r_acc_size),
    .i_rd_lane  (r_acc_lane),
    .i_rword    (r_rd_word),
    .o_be       (w_be),
    .o_wword    (w_wword),
    .o_rdata    (w_ld_data),
    .o_misalign (w_misalign),
    .o_illegal  (w_illegal)
  );

  // ---------------------------------------------------------------------------
  // Memory array. No reset here: contents are zeroed by the CLEAR sweep.
  // A store commits on its accept edge, so a load accepted on the next edge
  // already sees the new bytes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_store) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
    if (w_accept) r_rd_word <= r_mem[w_idx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc_valid <= 1'b0;
      r_acc_err   <= 1'b0;
      r_acc_we    <= 1'b0;
      r_acc_size  <= '0;
      r_acc_lane  <= '0;
    end else begin
      r_acc_valid <= w_accept;
      r_acc_err   <= w_err;
      r_acc_we    <= req_we;
      r_acc_size  <= req_size;
      r_acc_lane  <= w_lane;
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipeline: the array read takes the accept edge, the first stage
  // takes the next one, so RD_LATENCY stages give RD_LATENCY edges overall.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_stage0       = '0;
    w_stage0.valid = r_acc_valid;
    w_stage0.err   = r_acc_valid && r_acc_err;
    w_stage0.rdata = (r_acc_valid && !r_acc_err && !r_acc_we) ? w_ld_data : 32'h0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_stage0;
      for (int i = 1; i < RD_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign rsp_valid = r_pipe[RD_LATENCY-1].valid;
  assign rsp_err   = r_pipe[RD_LATENCY-1].err;
  assign rsp_rdata = r_pipe[RD_LATENCY-1].rdata;

endmodule

// File: tb/tb_data_memory_ls.sv
// -----------------------------------------------------------------------------
// tb_data_memory_ls
// Two instances share one request stream: dut (RD_LATENCY=1) is the main
// target, dut3 (RD_LATENCY=3) is checked for back-to-back ordering and for
// dropping in-flight responses on reset.
// -----------------------------------------------------------------------------
module tb_data_memory_ls;

  localparam logic [2:0] SB_ = 3'd0, SH_ = 3'd1, SW_ = 3'd2, SBU = 3'd4, SHU = 3'd5;
  localparam int MEM_SIZE = 256;
  localparam int NV = 32;

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_size = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;

  logic        req_ready, rsp_valid, rsp_err, init_busy;
  logic [31:0] rsp_rdata;
  logic        req_ready_3, rsp_valid_3, rsp_err_3, init_busy_3;
  logic [31:0] rsp_rdata_3;

  int n_checks = 0;
  int n_errs   = 0;

  vec_t        vecs [NV];
  logic [31:0] bb_exp [3];

  always #5 clk = ~clk;

  data_memory_ls #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(MEM_SIZE), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .init_busy(init_busy)
  );

  data_memory_ls #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(MEM_SIZE), .RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_3),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_3), .rsp_rdata(rsp_rdata_3), .rsp_err(rsp_err_3), .init_busy(init_busy_3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated request against the RD_LATENCY=1 instance
  task automatic do_req(input string name, input vec_t v);
    req_valid = 1'b1;
    req_we    = v.we;
    req_size  = v.size;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    tick();
    req_valid = 1'b0;
    chk({name, ".early"}, 32'(rsp_valid), 32'h0);
    tick();
    chk({name, ".valid"}, 32'(rsp_valid), 32'h1);
    chk({name, ".rdata"}, rsp_rdata, v.exp_rdata);
    chk({name, ".err"}, 32'(rsp_err), 32'(v.exp_err));
    $display("%s we=%0d size=%0d addr=%h wdata=%h -> valid=%0d rdata=%h err=%0d",
             name, v.we, v.size, v.addr, v.wdata, rsp_valid, rsp_rdata, rsp_err);
  endtask

  initial begin
    int   first_free;
    logic early_rsp;
    logic leaked;
    vec_t v;

    //                 we    size  addr          wdata         exp_rdata     err
    vecs[0]  = '{1'b0, SW_, 32'h000, 32'h0,        32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, SW_, 32'h010, 32'h80FF7F01, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b0, SB_, 32'h010, 32'h0,        32'h00000001, 1'b0};
    vecs[3]  = '{1'b0, SB_, 32'h013, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[4]  = '{1'b0, SBU, 32'h013, 32'h0,        32'h00000080, 1'b0};
    vecs[5]  = '{1'b0, SH_, 32'h012, 32'h0,        32'hFFFF80FF, 1'b0};
    vecs[6]  = '{1'b0, SHU, 32'h012, 32'h0,        32'h000080FF, 1'b0};
    vecs[7]  = '{1'b0, SB_, 32'h012, 32'h0,        32'hFFFFFFFF, 1'b0};
    vecs[8]  = '{1'b0, SH_, 32'h010, 32'h0,        32'h00007F01, 1'b0};
    vecs[9]  = '{1'b0, SW_, 32'h010, 32'h0,        32'h80FF7F01, 1'b0};
    vecs[10] = '{1'b1, SW_, 32'h020, 32'h11223344, 32'h00000000, 1'b0};
    vecs[11] = '{1'b1, SB_, 32'h021, 32'hFFFFFFAA, 32'h00000000, 1'b0};
    vecs[12] = '{1'b1, SH_, 32'h022, 32'h1234BEEF, 32'h00000000, 1'b0};
    vecs[13] = '{1'b0, SW_, 32'h020, 32'h0,        32'hBEEFAA44, 1'b0};
    vecs[14] = '{1'b1, SW_, 32'h004, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[15] = '{1'b0, SW_, 32'h022, 32'h0,        32'h00000000, 1'b1};
    vecs[16] = '{1'b1, SH_, 32'h005, 32'h00005555, 32'h00000000, 1'b1};
    vecs[17] = '{1'b0, SB_, 32'h400, 32'h0,        32'h00000000, 1'b1};
    vecs[18] = '{1'b0, 3'd3, 32'h000, 32'h0,       32'h00000000, 1'b1};
    vecs[19] = '{1'b0, SW_, 32'h004, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[20] = '{1'b1, SBU, 32'h008, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[21] = '{1'b0, SW_, 32'h008, 32'h0,        32'h00000000, 1'b0};
    vecs[22] = '{1'b1, SW_, 32'h3FC, 32'hCAFEF00D, 32'h00000000, 1'b0};
    vecs[23] = '{1'b0, SW_, 32'h3FC, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[24] = '{1'b0, SHU, 32'h013, 32'h0,        32'h00000000, 1'b1};
    vecs[25] = '{1'b0, 3'd6, 32'h000, 32'h0,       32'h00000000, 1'b1};
    vecs[26] = '{1'b1, SW_, 32'h000, 32'h0BADF00D, 32'h00000000, 1'b0};
    vecs[27] = '{1'b0, SH_, 32'h3FE, 32'h0,        32'hFFFFCAFE, 1'b0};
    vecs[28] = '{1'b1, SW_, 32'h1000, 32'h55555555, 32'h00000000, 1'b1};
    vecs[29] = '{1'b0, SW_, 32'h000, 32'h0,        32'h0BADF00D, 1'b0};
    vecs[30] = '{1'b1, SB_, 32'h3FF, 32'h00000011, 32'h00000000, 1'b0};
    vecs[31] = '{1'b0, SW_, 32'h3FC, 32'h0,        32'h11FEF00D, 1'b0};

    bb_exp[0] = 32'h0BADF00D;
    bb_exp[1] = 32'hDEADBEEF;
    bb_exp[2] = 32'h00000000;

    // ---- reset state ----
    repeat (3) tick();
    chk("rst.rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst.rsp_rdata", rsp_rdata, 32'h0);
    chk("rst.rsp_err", 32'(rsp_err), 32'h0);
    chk("rst.init_busy", 32'(init_busy), 32'h1);
    chk("rst.req_ready", 32'(req_ready), 32'h0);
    $display("reset held: busy=%0d ready=%0d valid=%0d", init_busy, req_ready, rsp_valid);

    // ---- clear sequence, with a load held pending throughout ----
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = SW_;
    req_addr  = 32'h0;
    reset     = 1'b1;
    first_free = -1;
    early_rsp  = 1'b0;
    for (int n = 1; n <= MEM_SIZE; n++) begin
      tick();
      if (rsp_valid) early_rsp = 1'b1;
      if (!init_busy && first_free < 0) first_free = n;
      if (n == MEM_SIZE - 1) chk("init.busy_at_255", 32'(init_busy), 32'h1);
    end
    chk("init.first_free_cycle", 32'(first_free), 32'(MEM_SIZE));
    chk("init.ready", 32'(req_ready), 32'h1);
    chk("init.no_rsp_during_clear", 32'(early_rsp), 32'h0);
    $display("clear done: busy first low at cycle %0d, ready=%0d", first_free, req_ready);
    tick();
    req_valid = 1'b0;
    chk("held.early", 32'(rsp_valid), 32'h0);
    tick();
    chk("held.valid", 32'(rsp_valid), 32'h1);
    chk("held.rdata", rsp_rdata, 32'h0);
    chk("held.err", 32'(rsp_err), 32'h0);
    $display("held LW @0 -> valid=%0d rdata=%h err=%0d", rsp_valid, rsp_rdata, rsp_err);

    // ---- table-driven single transactions ----
    for (int i = 0; i < NV; i++) begin
      do_req($sformatf("v%0d", i), vecs[i]);
    end

    // ---- back-to-back loads: ordering and latency on both instances ----
    repeat (4) tick();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = SW_;
    req_addr  = 32'h0;
    for (int k = 0; k < 7; k++) begin
      logic exp1, exp3;
      tick();
      if (k < 2) req_addr = 32'((k + 1) * 4);
      else       req_valid = 1'b0;
      exp3 = (k >= 3 && k <= 5);
      exp1 = (k >= 1 && k <= 3);
      chk($sformatf("bb.lat3.valid.k%0d", k), 32'(rsp_valid_3), 32'(exp3));
      if (exp3) chk($sformatf("bb.lat3.rdata.k%0d", k), rsp_rdata_3, bb_exp[k-3]);
      chk($sformatf("bb.lat1.valid.k%0d", k), 32'(rsp_valid), 32'(exp1));
      if (exp1) chk($sformatf("bb.lat1.rdata.k%0d", k), rsp_rdata, bb_exp[k-1]);
      $display("bb k=%0d lat3 valid=%0d rdata=%h | lat1 valid=%0d rdata=%h",
               k, rsp_valid_3, rsp_rdata_3, rsp_valid, rsp_rdata);
    end

    // ---- reset with two loads in flight ----
    repeat (2) tick();
    req_valid = 1'b1;
    req_addr  = 32'h004;
    tick();
    req_addr  = 32'h010;
    tick();
    req_valid = 1'b0;
    reset     = 1'b0;
    #1;
    chk("midrst.valid3_now", 32'(rsp_valid_3), 32'h0);
    chk("midrst.rdata3_now", rsp_rdata_3, 32'h0);
    leaked = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rsp_valid_3 || rsp_valid) leaked = 1'b1;
    end
    chk("midrst.no_leak", 32'(leaked), 32'h0);
    $display("reset mid-flight: leaked=%0d", leaked);
    reset = 1'b1;
    tick();
    chk("midrst.busy", 32'(init_busy), 32'h1);
    chk("midrst.busy3", 32'(init_busy_3), 32'h1);
    repeat (MEM_SIZE - 1) tick();
    chk("midrst.ready", 32'(req_ready), 32'h1);

    v = '{1'b0, SW_, 32'h004, 32'h0, 32'h0, 1'b0};
    do_req("post.lw04", v);
    v = '{1'b0, SW_, 32'h010, 32'h0, 32'h0, 1'b0};
    do_req("post.lw10", v);
    v = '{1'b0, SW_, 32'h3FC, 32'h0, 32'h0, 1'b0};
    do_req("post.lw3fc", v);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
